// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic port_idx_t;

    // All-ones address; sliced down to ADDR_W where it is compared.
    localparam logic [31:0] IO_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin winner select; the last-grant pointer is held by the caller.
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  port_idx_t  i_last,
    output logic [1:0] o_gnt
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last == 1'b1) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the single-port data RAM.
// Define DMEM_ARB_IO_EN to map the all-ones address to an I/O register instead of RAM.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_IO_EN
    ,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_wr
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    port_idx_t         r_idx;
    port_idx_t         r_last;
    logic [1:0]        w_win;
    logic              w_issue;
    logic              w_resp;
    logic              w_is_io;
    logic              w_ram_en;
    logic [DATA_W-1:0] w_rdata;

    rr_arbiter2 u_rr (
        .i_req  ({req1, req0}),
        .i_last (r_last),
        .o_gnt  (w_win)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req0 || req1) w_next = ISSUE;
            ISSUE:   w_next = r_we ? IDLE : RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: the request latches are reset too, so decoded outputs are clean 0 straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            if (r_state == IDLE && (req0 || req1)) begin
                r_idx   <= w_win[1];
                r_we    <= w_win[1] ? we1    : we0;
                r_addr  <= w_win[1] ? addr1  : addr0;
                r_wdata <= w_win[1] ? wdata1 : wdata0;
            end
            if (r_state == ISSUE) r_last <= r_idx;
        end
    end

    assign w_issue = (r_state == ISSUE);
    assign w_resp  = (r_state == RESP);

`ifdef DMEM_ARB_IO_EN
    logic [DATA_W-1:0] r_io_out;
    logic              r_io_wr;

    assign w_is_io = (r_addr == IO_ADDR[ADDR_W-1:0]);
    assign w_rdata = w_is_io ? io_in : mem_rdata;

    // The I/O register commits on the edge that closes ISSUE, so a reset in ISSUE drops it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_io_out <= '0;
            r_io_wr  <= 1'b0;
        end else begin
            r_io_wr <= w_issue && r_we && w_is_io;
            if (w_issue && r_we && w_is_io) r_io_out <= r_wdata;
        end
    end

    assign io_out = r_io_out;
    assign io_wr  = r_io_wr;
`else
    assign w_is_io = 1'b0;
    assign w_rdata = mem_rdata;
`endif

    assign w_ram_en  = w_issue && !w_is_io;
    assign gnt0      = w_issue && (r_idx == 1'b0);
    assign gnt1      = w_issue && (r_idx == 1'b1);
    assign mem_en    = w_ram_en;
    assign mem_we    = w_ram_en && r_we;
    assign mem_addr  = w_ram_en ? r_addr  : '0;
    assign mem_wdata = w_ram_en ? r_wdata : '0;
    assign rvalid0   = w_resp && (r_idx == 1'b0);
    assign rvalid1   = w_resp && (r_idx == 1'b1);
    assign rdata0    = rvalid0 ? w_rdata : '0;
    assign rdata1    = rvalid1 ? w_rdata : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port 256x8 synchronous data RAM between the processor load/store path (port 0) and a secondary requester such as a DMA or debug loader (port 1). It serialises accesses with a req/gnt handshake and round-robin fairness. It drives the RAM control pins and returns read data with fixed latency. It sits between the requesters and the data RAM, replacing the direct processor-to-RAM connection.

## Interface
- ADDR_W, 8, address width; the RAM depth is 2**ADDR_W.
- DATA_W, 8, data width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0, req1  in  1  access request from port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read; held stable while req is high.
- addr0, addr1  in  ADDR_W  access address; held stable while req is high.
- wdata0, wdata1  in  DATA_W  write data; held stable while req is high.
- gnt0, gnt1  out  1  one-cycle acceptance pulse to the corresponding port.
- rvalid0, rvalid1  out  1  read data valid for one cycle.
- rdata0, rdata1  out  DATA_W  read data, qualified by rvalid.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0.
- io_in  in  DATA_W  external input; present only with DMEM_ARB_IO_EN.
- io_out  out  DATA_W  external output register; present only with DMEM_ARB_IO_EN.
- io_wr  out  1  io_out update strobe; present only with DMEM_ARB_IO_EN.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: drive the RAM and pulse gnt.
  - RESP: return read data.
- In IDLE:
  - No req: stay in IDLE.
  - Otherwise: select the winner, latch its we/addr/wdata and index, and go to ISSUE.
- Round-robin rule:
  - A sole requester always wins.
  - On a tie, the winner is the port not granted last.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- In ISSUE:
  - gntN=1 for the winner only.
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Write: next state IDLE.
  - Read: next state RESP.
- In RESP: rvalidN=1 and rdataN=mem_rdata for the latched port, then next state IDLE.
- rdata of the non-selected port is 0. mem_addr and mem_wdata are 0 whenever mem_en=0.
- Requester rule: drop req on the edge that ends the gnt cycle unless another access is pending.
- A req dropped before gnt withdraws the request. A req still high in IDLE is a new request.
- The arbiter never modifies the latched request between IDLE and the return to IDLE.

## Timing
- Reset values:
  - State IDLE, pointer 1.
  - gnt0/1, rvalid0/1, mem_en and mem_we are 0.
  - rdata0/1, mem_addr, mem_wdata, io_out and io_wr are 0.
- Reset mid-operation: the transaction is dropped with no gnt, mem_en or rvalid afterwards. A write in ISSUE at the reset edge is not guaranteed to commit.
- Request sampled at edge k (IDLE):
  - gnt and mem_en are high in cycle k+1.
  - Read data is valid in cycle k+2.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Simultaneous requests: the loser's req stays high and is granted at the next IDLE. Worst-case wait is one foreign access (max 3 cycles).
- All outputs are registered or decoded from the state register only. There is no combinational path from req to gnt.

## Configuration
- Macro: DMEM_ARB_IO_EN.
- Defined: address all-ones (8'hFF at ADDR_W=8) is a memory-mapped I/O port, not RAM.
  - Write: mem_en stays 0; io_out takes the latched wdata at the end of ISSUE; io_wr pulses high for the cycle after ISSUE.
  - Read: mem_en stays 0; the RESP cycle returns the io_in value sampled during RESP.
  - gnt and latency are unchanged.
- Undefined: the all-ones address is ordinary RAM. The io_in/io_out/io_wr ports do not exist.

## Structure
- Package dmem_arb_pkg:
  - State enum {IDLE, ISSUE, RESP}.
  - IO_ADDR constant (all-ones).
  - Port index type (1 bit).
- Sub-module rr_arbiter2: two requests plus the last-grant pointer in, one-hot winner out; the pointer is updated on ISSUE.
- FSM, latches, RAM mux and the I/O register stay in dmem_arbiter.

## Test plan
- Single read: RAM[0x10]=0x5A; port 0 read 0x10 -> gnt0 at k+1, rvalid0=1 with rdata0=0x5A at k+2, port 1 outputs all 0.
- Simultaneous: both ports request writes (0x20←0x11 from port 0, 0x21←0x22 from port 1) from reset -> port 0 granted first, port 1 two cycles later, RAM holds 0x11 and 0x22.
- Fairness: both ports hold continuous reads -> grants strictly alternate 0,1,0,1 every 3 cycles; no port is granted twice in a row.
- Reset mid-read: assert reset during ISSUE -> no rvalid, all outputs 0; next req is accepted normally with port 0 winning a tie.
- IO_EN build: write 0xFF←0xC3 -> io_out=0xC3, io_wr one-cycle pulse, mem_en never high; read 0xFF with io_in=0x7E -> rdata=0x7E.
- Non-IO build: write 0xFF←0xC3, then read 0xFF -> rdata=0xC3 via RAM, with mem_en asserted on both accesses.
